// File: rtl/spi_data_path_mx.sv
`default_nettype none
// ============================================================================
// Module      : spi_data_path_mx
// Description : Oversampled mode-0 SPI slave data path (1/2/4 lanes) decoding
//               CMD -> ADDR -> [DUMMY] -> DATA frames onto a register bus.
//               Optional burst addressing enabled by defining SPI_BURST_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_data_path_mx #(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16,
    parameter int DUMMY_CYC   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic [3:0]        mosi,
    input  logic [1:0]        spi_mode,
    input  logic [DATA_W-1:0] rdata,
    input  logic              rd_valid,
    output logic [3:0]        miso,
    output logic [3:0]        miso_oe,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic              wr_valid,
    output logic              rd_req,
    output logic [3:0]        status,
    output logic              busy
);
    localparam int SH_W    = (ADDR_W > DATA_W) ? ((ADDR_W > 8) ? ADDR_W : 8)
                                               : ((DATA_W > 8) ? DATA_W : 8);
    localparam int CNT_MAX = (SH_W > DUMMY_CYC) ? SH_W : DUMMY_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1) + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_ADDR  = 3'd2,
        S_DUMMY = 3'd3,
        S_WDATA = 3'd4,
        S_RDATA = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q;
    logic [3:0]             mosi_sync_q [SYNC_STAGES];
    logic                   sclk_prev_q, cs_prev_q;
    logic                   sclk_s, cs_s, sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [3:0]             mosi_s;

    state_t                 state_q, state_d;
    logic [1:0]             lanes_q, lanes_d;
    logic                   is_read_q, is_read_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_nx, lb;
    logic [SH_W-1:0]        rx_sh_q, rx_sh_d, rx_nx;
    logic [DATA_W-1:0]      tx_sh_q, tx_sh_d, tx_nx;
    logic                   pend_q, pend_d, shift_pend_q, shift_pend_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic                   wr_valid_q, wr_valid_d, rd_req_q, rd_req_d, busy_q, busy_d;
    logic [3:0]             status_q, status_d, miso_q, miso_d, oe_q, oe_d;
`ifdef SPI_BURST_EN
    logic                   word_done_q, word_done_d;
`endif

    // Cold reset assumes cs_n low so that a frame already in flight is never re-entered mid-way.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) mosi_sync_q[i] <= 4'h0;
        end else begin
            sclk_sync_q    <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            cs_sync_q      <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            mosi_sync_q[0] <= mosi;
            for (int i = 1; i < SYNC_STAGES; i++) mosi_sync_q[i] <= mosi_sync_q[i-1];
            sclk_prev_q    <= sclk_s;
            cs_prev_q      <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign cnt_nx    = cnt_q + lb;

    always_comb begin
        case (lanes_q)
            2'd0: begin
                lb    = CNT_W'(1);
                rx_nx = {rx_sh_q[SH_W-2:0], mosi_s[0]};
                tx_nx = {tx_sh_q[DATA_W-2:0], 1'b0};
            end
            2'd1: begin
                lb    = CNT_W'(2);
                rx_nx = {rx_sh_q[SH_W-3:0], mosi_s[1:0]};
                tx_nx = {tx_sh_q[DATA_W-3:0], 2'b00};
            end
            default: begin
                lb    = CNT_W'(4);
                rx_nx = {rx_sh_q[SH_W-5:0], mosi_s};
                tx_nx = {tx_sh_q[DATA_W-5:0], 4'h0};
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        lanes_d      = lanes_q;
        is_read_d    = is_read_q;
        cnt_d        = cnt_q;
        rx_sh_d      = rx_sh_q;
        tx_sh_d      = tx_sh_q;
        pend_d       = pend_q;
        shift_pend_d = shift_pend_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        status_d     = status_q;
        wr_valid_d   = 1'b0;
        rd_req_d     = 1'b0;
`ifdef SPI_BURST_EN
        word_done_d  = word_done_q;
        // Advance after the write pulse so addr stays valid alongside wr_valid.
        if (wr_valid_q) addr_d = addr_q + ADDR_W'(1);
`endif
        if (rd_valid && pend_q) begin
            tx_sh_d = rdata;
            pend_d  = 1'b0;
        end

        case (state_q)
            S_IDLE: if (cs_fall) begin
                state_d      = S_CMD;
                cnt_d        = '0;
                lanes_d      = (spi_mode == 2'b11) ? 2'b00 : spi_mode;
                status_d     = (spi_mode == 2'b11) ? 4'b1000 : 4'b0000;
                pend_d       = 1'b0;
                shift_pend_d = 1'b0;
                tx_sh_d      = '0;
`ifdef SPI_BURST_EN
                word_done_d  = 1'b0;
`endif
            end
            S_CMD: if (sclk_rise) begin
                rx_sh_d = rx_nx;
                cnt_d   = cnt_nx;
                if (cnt_nx == CNT_W'(8)) begin
                    is_read_d = rx_nx[7];
                    cnt_d     = '0;
                    state_d   = S_ADDR;
                end
            end
            S_ADDR: if (sclk_rise) begin
                rx_sh_d = rx_nx;
                cnt_d   = cnt_nx;
                if (cnt_nx == CNT_W'(ADDR_W)) begin
                    addr_d = rx_nx[ADDR_W-1:0];
                    cnt_d  = '0;
                    if (is_read_q) begin
                        rd_req_d = 1'b1;
                        pend_d   = 1'b1;
                        state_d  = S_DUMMY;
                    end else begin
                        state_d  = S_WDATA;
                    end
                end
            end
            S_DUMMY: if (sclk_rise) begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q + CNT_W'(1) == CNT_W'(DUMMY_CYC)) begin
                    cnt_d        = '0;
                    shift_pend_d = 1'b0;
                    state_d      = S_RDATA;
                    if (pend_d) begin
                        pend_d      = 1'b0;
                        tx_sh_d     = '0;
                        status_d[1] = 1'b1;
                    end
                end
            end
            S_WDATA: if (sclk_rise) begin
                rx_sh_d = rx_nx;
                cnt_d   = cnt_nx;
                if (cnt_nx == CNT_W'(DATA_W)) begin
                    wdata_d    = rx_nx[DATA_W-1:0];
                    wr_valid_d = 1'b1;
                    cnt_d      = '0;
`ifdef SPI_BURST_EN
                    word_done_d = 1'b1;
`else
                    state_d    = S_DONE;
`endif
                end
            end
            S_RDATA: begin
                if (sclk_rise) begin
                    cnt_d        = cnt_nx;
                    shift_pend_d = 1'b1;
                    if (cnt_nx == CNT_W'(DATA_W)) begin
                        cnt_d        = '0;
                        shift_pend_d = 1'b0;
`ifdef SPI_BURST_EN
                        word_done_d  = 1'b1;
                        addr_d       = addr_q + ADDR_W'(1);
                        rd_req_d     = 1'b1;
                        pend_d       = 1'b1;
                        tx_sh_d      = '0;
`else
                        state_d      = S_DONE;
`endif
                    end
                end else if (sclk_fall) begin
                    if (shift_pend_q) begin
                        tx_sh_d      = tx_nx;
                        shift_pend_d = 1'b0;
                    end
`ifdef SPI_BURST_EN
                    // Next word must be loaded before its first bits are presented.
                    else if (pend_d) begin
                        pend_d      = 1'b0;
                        status_d[1] = 1'b1;
                    end
`endif
                end
            end
            default: ;
        endcase

        // Edge work above is already folded into state_d before cs_n is considered.
        if (cs_rise && state_q != S_IDLE) begin
            case (state_d)
                S_DONE: status_d[0] = 1'b1;
`ifdef SPI_BURST_EN
                S_WDATA, S_RDATA: begin
                    if (cnt_d == '0 && word_done_d) status_d[0] = 1'b1;
                    else                            status_d[2] = 1'b1;
                end
`endif
                default: status_d[2] = 1'b1;
            endcase
            state_d = S_IDLE;
            pend_d  = 1'b0;
        end

        oe_d = 4'b0000;
        if (state_d == S_RDATA) begin
            case (lanes_d)
                2'd0:    oe_d = 4'b0001;
                2'd1:    oe_d = 4'b0011;
                default: oe_d = 4'b1111;
            endcase
        end
        case (lanes_d)
            2'd0:    miso_d = {3'b000, tx_sh_d[DATA_W-1]};
            2'd1:    miso_d = {2'b00, tx_sh_d[DATA_W-1 -: 2]};
            default: miso_d = tx_sh_d[DATA_W-1 -: 4];
        endcase
        miso_d = miso_d & oe_d;
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            lanes_q      <= 2'b00;
            is_read_q    <= 1'b0;
            cnt_q        <= '0;
            rx_sh_q      <= '0;
            tx_sh_q      <= '0;
            pend_q       <= 1'b0;
            shift_pend_q <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wr_valid_q   <= 1'b0;
            rd_req_q     <= 1'b0;
            status_q     <= 4'b0000;
            miso_q       <= 4'b0000;
            oe_q         <= 4'b0000;
            busy_q       <= 1'b0;
`ifdef SPI_BURST_EN
            word_done_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            lanes_q      <= lanes_d;
            is_read_q    <= is_read_d;
            cnt_q        <= cnt_d;
            rx_sh_q      <= rx_sh_d;
            tx_sh_q      <= tx_sh_d;
            pend_q       <= pend_d;
            shift_pend_q <= shift_pend_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wr_valid_q   <= wr_valid_d;
            rd_req_q     <= rd_req_d;
            status_q     <= status_d;
            miso_q       <= miso_d;
            oe_q         <= oe_d;
            busy_q       <= busy_d;
`ifdef SPI_BURST_EN
            word_done_q  <= word_done_d;
`endif
        end
    end

    assign miso     = miso_q;
    assign miso_oe  = oe_q;
    assign addr     = addr_q;
    assign wdata    = wdata_q;
    assign wr_valid = wr_valid_q;
    assign rd_req   = rd_req_q;
    assign status   = status_q;
    assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_data_path_mx.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_data_path_mx
// Description : Directed, table-driven bench for spi_data_path_mx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_data_path_mx;
    localparam int HALF = 6;

    logic        clk = 1'b0, reset = 1'b1, sclk = 1'b0, cs_n = 1'b1;
    logic [3:0]  mosi = 4'h0;
    logic [1:0]  spi_mode = 2'b00;
    logic [15:0] rdata = 16'h0;
    logic        rd_valid = 1'b0;
    logic [3:0]  miso, miso_oe, status;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic        wr_valid, rd_req, busy;

    always #5 clk = ~clk;

    spi_data_path_mx dut (
        .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .spi_mode(spi_mode), .rdata(rdata), .rd_valid(rd_valid),
        .miso(miso), .miso_oe(miso_oe), .addr(addr), .wdata(wdata),
        .wr_valid(wr_valid), .rd_req(rd_req), .status(status), .busy(busy)
    );

    int n_checks = 0, n_errors = 0;

    // Bus monitor: cumulative pulse counts and last captured values.
    int          wr_cnt = 0, rd_cnt = 0;
    logic [19:0] wr_addr_last = '0, rd_addr_last = '0;
    logic [15:0] wr_data_last = '0;
`ifdef SPI_BURST_EN
    logic [19:0] wr_addr_prev = '0;
    logic [15:0] wr_data_prev = '0;
`endif
    always @(negedge clk) begin
        if (wr_valid) begin
            wr_cnt       <= wr_cnt + 1;
            wr_addr_last <= addr;
            wr_data_last <= wdata;
`ifdef SPI_BURST_EN
            wr_addr_prev <= wr_addr_last;
            wr_data_prev <= wr_data_last;
`endif
        end
        if (rd_req) begin
            rd_cnt       <= rd_cnt + 1;
            rd_addr_last <= addr;
        end
    end

    // Register-file model: answers rd_req after rsp_dly clocks, then sends a stray second strobe.
    int          rsp_dly = -1;
    logic [15:0] rsp_data = '0;
    always begin
        @(negedge clk);
        if (rd_req && rsp_dly >= 0) begin
            repeat (rsp_dly) @(negedge clk);
            rdata = rsp_data; rd_valid = 1'b1;
            @(negedge clk);
            rd_valid = 1'b0; rdata = 16'h0;
            @(negedge clk);
            rdata = ~rsp_data; rd_valid = 1'b1;
            @(negedge clk);
            rd_valid = 1'b0; rdata = 16'h0;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic spi_clk(input logic [3:0] m, output logic [3:0] so, output logic [3:0] oe);
        mosi = m;
        repeat (HALF) @(negedge clk);
        so = miso; oe = miso_oe;
        sclk = 1'b1;
        repeat (HALF) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] val, input int nbits, input int lanes);
        logic [3:0] so, oe, chunk;
        for (int i = nbits - lanes; i >= 0; i -= lanes) begin
            chunk = 4'((val >> i) & ((32'd1 << lanes) - 32'd1));
            spi_clk(chunk, so, oe);
        end
    endtask

    task automatic recv_bits(input int nbits, input int lanes, output logic [31:0] val,
                             output logic [3:0] oe_all);
        logic [3:0] so, oe;
        val = '0; oe_all = 4'hF;
        for (int i = 0; i < nbits / lanes; i++) begin
            spi_clk(4'h0, so, oe);
            val    = (val << lanes) | 32'(so & 4'((32'd1 << lanes) - 32'd1));
            oe_all = oe_all & oe;
        end
    endtask

    function automatic int lanes_of(input logic [1:0] m);
        return (m == 2'b01) ? 2 : (m == 2'b10) ? 4 : 1;
    endfunction

    task automatic cs_start(input logic [1:0] m);
        @(negedge clk);
        spi_mode = m; cs_n = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_end();
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic [7:0]  cmd;
        logic [19:0] addr;
        logic [15:0] data;
        int          rd_dly;
        logic [3:0]  exp_status;
        int          exp_wr;
        int          exp_rd;
        logic [15:0] exp_word;
        logic [3:0]  exp_oe;
    } vec_t;

    task automatic run_vec(input vec_t v, input int idx);
        int          w0, r0, l;
        logic [31:0] word;
        logic [3:0]  oe_all, so, oe;
        string       tag;
        tag = $sformatf("v%0d", idx);
        w0 = wr_cnt; r0 = rd_cnt; l = lanes_of(v.mode);
        rsp_dly = v.rd_dly; rsp_data = v.data;
        cs_start(v.mode);
        check({tag, ".busy_in_frame"}, 32'(busy), 32'd1);
        send_bits(32'(v.cmd), 8, l);
        send_bits(32'(v.addr), 20, l);
        if (v.cmd[7]) begin
            repeat (4) spi_clk(4'h0, so, oe);
            recv_bits(16, l, word, oe_all);
            check({tag, ".miso_word"}, word, 32'(v.exp_word));
            check({tag, ".miso_oe"}, 32'(oe_all), 32'(v.exp_oe));
            check({tag, ".rd_addr"}, 32'(rd_addr_last), 32'(v.addr));
        end else begin
            send_bits(32'(v.data), 16, l);
            check({tag, ".wdata"}, 32'(wdata), 32'(v.exp_word));
            check({tag, ".wr_addr"}, 32'(wr_addr_last), 32'(v.addr));
        end
        cs_end();
        check({tag, ".wr_pulses"}, 32'(wr_cnt - w0), 32'(v.exp_wr));
        check({tag, ".rd_pulses"}, 32'(rd_cnt - r0), 32'(v.exp_rd));
        check({tag, ".addr"}, 32'(addr), 32'(v.addr));
        check({tag, ".status"}, 32'(status), 32'(v.exp_status));
        check({tag, ".busy_after"}, 32'(busy), 32'd0);
        check({tag, ".oe_after"}, 32'(miso_oe), 32'd0);
    endtask

    initial begin
        vec_t vecs[7];
        int   w0, r0;
        vecs[0] = '{2'b00, 8'h00, 20'h12345, 16'hC69A, -1, 4'b0001, 1, 0, 16'hC69A, 4'h0};
        vecs[1] = '{2'b10, 8'h80, 20'h00010, 16'hC69A,  3, 4'b0001, 0, 1, 16'hC69A, 4'hF};
        vecs[2] = '{2'b01, 8'h7F, 20'hFEDCB, 16'h0F0F, -1, 4'b0001, 1, 0, 16'h0F0F, 4'h0};
        vecs[3] = '{2'b00, 8'hFF, 20'h00ABC, 16'h5A3C,  1, 4'b0001, 0, 1, 16'h5A3C, 4'h1};
        vecs[4] = '{2'b10, 8'h80, 20'h54321, 16'hBEEF, -1, 4'b0011, 0, 1, 16'h0000, 4'hF};
        vecs[5] = '{2'b11, 8'h00, 20'h0A5A5, 16'h1234, -1, 4'b1001, 1, 0, 16'h1234, 4'h0};
        vecs[6] = '{2'b01, 8'h81, 20'h00003, 16'h9E37,  0, 4'b0001, 0, 1, 16'h9E37, 4'h3};

        repeat (3) @(negedge clk);
        check("rst.miso", 32'(miso), 32'd0);
        check("rst.miso_oe", 32'(miso_oe), 32'd0);
        check("rst.addr", 32'(addr), 32'd0);
        check("rst.wdata", 32'(wdata), 32'd0);
        check("rst.wr_valid", 32'(wr_valid), 32'd0);
        check("rst.rd_req", 32'(rd_req), 32'd0);
        check("rst.status", 32'(status), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Abort: cs_n rises after 12 of the 20 address bits of a read.
        w0 = wr_cnt; r0 = rd_cnt; rsp_dly = 2;
        cs_start(2'b00);
        send_bits(32'h80, 8, 1);
        send_bits(32'h123, 12, 1);
        cs_end();
        check("abort.wr_pulses", 32'(wr_cnt - w0), 32'd0);
        check("abort.rd_pulses", 32'(rd_cnt - r0), 32'd0);
        check("abort.status", 32'(status), 32'b0100);
        check("abort.busy", 32'(busy), 32'd0);

        // Two back-to-back dual-lane words at the top of the address space.
        w0 = wr_cnt;
        cs_start(2'b01);
        send_bits(32'h00, 8, 2);
        send_bits(32'hFFFFF, 20, 2);
        send_bits(32'h1111, 16, 2);
        send_bits(32'h2222, 16, 2);
        cs_end();
        check("burst.status", 32'(status), 32'b0001);
`ifdef SPI_BURST_EN
        check("burst.wr_pulses", 32'(wr_cnt - w0), 32'd2);
        check("burst.addr0", 32'(wr_addr_prev), 32'hFFFFF);
        check("burst.data0", 32'(wr_data_prev), 32'h1111);
        check("burst.addr1", 32'(wr_addr_last), 32'h00000);
        check("burst.data1", 32'(wr_data_last), 32'h2222);
`else
        check("burst.wr_pulses", 32'(wr_cnt - w0), 32'd1);
        check("burst.addr", 32'(wr_addr_last), 32'hFFFFF);
        check("burst.wdata", 32'(wdata), 32'h1111);
`endif

        // Reset in the middle of the write-data phase.
        w0 = wr_cnt;
        cs_start(2'b00);
        send_bits(32'h00, 8, 1);
        send_bits(32'h00777, 20, 1);
        send_bits(32'hAB, 8, 1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst.addr", 32'(addr), 32'd0);
        check("midrst.wdata", 32'(wdata), 32'd0);
        check("midrst.status", 32'(status), 32'd0);
        check("midrst.busy", 32'(busy), 32'd0);
        reset = 1'b0;
        send_bits(32'hCD, 8, 1);
        cs_end();
        check("midrst.wr_pulses", 32'(wr_cnt - w0), 32'd0);
        check("midrst.status_after", 32'(status), 32'd0);
        check("midrst.busy_after", 32'(busy), 32'd0);
        run_vec(vecs[0], 7);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
